rv32i_run_ctrl: RTL and testbench

//  Synthesizable run controller for rv32i_core_top in sim and FPGA bring-up.

---
 rtl/rv32i_run_ctrl.sv | 138 +++++++++++++
 tb/tb_rv32i_run_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_run_ctrl.sv
// Run controller for rv32i_core_top: sequences core reset, watches for halt or timeout,
// and buffers register writebacks in a trace FIFO drained over a valid/ready port.
module rv32i_run_ctrl #(
    parameter int unsigned     XLEN           = 32,
    parameter int unsigned     RESET_CYCLES   = 2,
    parameter int unsigned     TIMEOUT_CYCLES = 200,
    parameter int unsigned     TRACE_DEPTH    = 16,
    parameter logic [XLEN-1:0] HALT_INSN      = 32'h00100073
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            core_rst_o,
    input  logic [XLEN-1:0] instruction_if_id_i,
    input  logic [4:0]      addr_wb_i,
    input  logic [XLEN-1:0] data_wb_i,
    output logic            trace_valid_o,
    input  logic            trace_ready_i,
    output logic [4:0]      trace_addr_o,
    output logic [XLEN-1:0] trace_data_o,
    output logic            trace_overflow_o,
    output logic [2:0]      state_o,
    output logic [31:0]     cycle_count_o,
    output logic            halted_o,
    output logic            timeout_o,
    output logic            done_o
);
    localparam int unsigned PW  = $clog2(TRACE_DEPTH);
    localparam int unsigned RCW = $clog2(RESET_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } trace_ent_t;

    state_e         state_q, state_d;
    logic [RCW-1:0] rst_cnt_q;
    logic           clr, halt_hit, tmo_hit;

    logic [PW:0]    wr_ptr_q, rd_ptr_q;
    trace_ent_t     mem_q [TRACE_DEPTH];
    trace_ent_t     head;
    logic           empty, full, push, pop, accept;

    // Extra pointer bit distinguishes a full FIFO from an empty one.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop    = !empty && trace_ready_i;
    assign push   = (state_q == S_RUN) && (addr_wb_i != 5'd0);
    assign accept = push && (!full || pop);

    assign head          = mem_q[rd_ptr_q[PW-1:0]];
    assign trace_valid_o = !empty;
    assign trace_addr_o  = head.addr;
    assign trace_data_o  = head.data;

    assign core_rst_o = (state_q != S_RUN);
    assign done_o     = (state_q == S_DONE);
    assign state_o    = state_q;

    always_comb begin
        state_d  = state_q;
        clr      = 1'b0;
        halt_hit = 1'b0;
        tmo_hit  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_RESET;
                    clr     = 1'b1;
                end
            end
            S_RESET: begin
                if (rst_cnt_q == RCW'(RESET_CYCLES - 1)) state_d = S_RUN;
            end
            S_RUN: begin
                // Halt takes priority over a timeout landing on the same cycle.
                if (instruction_if_id_i == HALT_INSN) begin
                    halt_hit = 1'b1;
                    state_d  = S_DRAIN;
                end else if (cycle_count_o == 32'(TIMEOUT_CYCLES - 1)) begin
                    tmo_hit = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (empty) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q          <= S_IDLE;
            rst_cnt_q        <= '0;
            cycle_count_o    <= '0;
            halted_o         <= 1'b0;
            timeout_o        <= 1'b0;
            trace_overflow_o <= 1'b0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
        end else begin
            state_q <= state_d;
            if (clr) begin
                rst_cnt_q        <= '0;
                cycle_count_o    <= '0;
                halted_o         <= 1'b0;
                timeout_o        <= 1'b0;
                trace_overflow_o <= 1'b0;
                wr_ptr_q         <= '0;
                rd_ptr_q         <= '0;
            end else begin
                if (state_q == S_RESET) rst_cnt_q <= rst_cnt_q + RCW'(1);
                if (state_q == S_RUN) cycle_count_o <= cycle_count_o + 32'd1;
                if (halt_hit) halted_o <= 1'b1;
                if (tmo_hit) timeout_o <= 1'b1;
                if (push && !accept) trace_overflow_o <= 1'b1;
                if (accept) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
                if (pop) rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && !clr) mem_q[wr_ptr_q[PW-1:0]] <= {addr_wb_i, data_wb_i};
    end

endmodule

// File: tb/tb_rv32i_run_ctrl.sv
// Directed bench for rv32i_run_ctrl: trace entries go through a scoreboard queue,
// FSM/flag behaviour is checked step by step.
`timescale 1ns/1ps
module tb_rv32i_run_ctrl;
    localparam int DEPTH = 4;
    localparam logic [31:0] HALT = 32'h00100073;
    localparam logic [31:0] NOP  = 32'h00000013;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        core_rst_o;
    logic [31:0] instruction_if_id_i;
    logic [4:0]  addr_wb_i;
    logic [31:0] data_wb_i;
    logic        trace_valid_o;
    logic        trace_ready_i;
    logic [4:0]  trace_addr_o;
    logic [31:0] trace_data_o;
    logic        trace_overflow_o;
    logic [2:0]  state_o;
    logic [31:0] cycle_count_o;
    logic        halted_o;
    logic        timeout_o;
    logic        done_o;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   rc       = 0;
    bit   running  = 1'b0;
    bit   exp_ovf  = 1'b0;
    ent_t sb[$];

    rv32i_run_ctrl #(
        .XLEN(32), .RESET_CYCLES(3), .TIMEOUT_CYCLES(20),
        .TRACE_DEPTH(DEPTH), .HALT_INSN(HALT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .core_rst_o(core_rst_o),
        .instruction_if_id_i(instruction_if_id_i), .addr_wb_i(addr_wb_i),
        .data_wb_i(data_wb_i), .trace_valid_o(trace_valid_o),
        .trace_ready_i(trace_ready_i), .trace_addr_o(trace_addr_o),
        .trace_data_o(trace_data_o), .trace_overflow_o(trace_overflow_o),
        .state_o(state_o), .cycle_count_o(cycle_count_o), .halted_o(halted_o),
        .timeout_o(timeout_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (running) rc++;
    endtask

    // Drive one writeback; the model predicts acceptance from the queued count.
    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bit   acc;
        ent_t e;
        addr_wb_i = a;
        data_wb_i = d;
        acc = (a != 5'd0) && ((sb.size() < DEPTH) || (trace_ready_i && sb.size() > 0));
        if (acc) begin
            e.a = a;
            e.d = d;
            sb.push_back(e);
        end else if (a != 5'd0) begin
            exp_ovf = 1'b1;
        end
        tick();
        addr_wb_i = 5'd0;
        chk("overflow", trace_overflow_o, exp_ovf);
    endtask

    task automatic enter_run();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        exp_ovf = 1'b0;
        chk("start_clr_halted", halted_o, 0);
        chk("start_clr_timeout", timeout_o, 0);
        chk("start_clr_done", done_o, 0);
        chk("start_clr_count", cycle_count_o, 0);
        chk("start_clr_ovf", trace_overflow_o, 0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            chk("reset_state", state_o, 1);
            chk("reset_core_rst", core_rst_o, 1);
        end
        tick();
        chk("run_state", state_o, 2);
        chk("run_core_rst", core_rst_o, 0);
        chk("run_valid_empty", trace_valid_o, 0);
        running = 1'b1;
        rc = 0;
    endtask

    always @(negedge clk_i) begin
        ent_t e;
        if (rst_i === 1'b1 && trace_valid_o && trace_ready_i) begin
            if (sb.size() == 0) begin
                chk("trace_extra", trace_valid_o, 0);
            end else begin
                e = sb.pop_front();
                chk("trace_addr", trace_addr_o, e.a);
                chk("trace_data", trace_data_o, e.d);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b0;
        start_i = 1'b0;
        trace_ready_i = 1'b0;
        instruction_if_id_i = NOP;
        addr_wb_i = 5'd0;
        data_wb_i = 32'd0;
        repeat (3) tick();
        chk("rst_state", state_o, 0);
        chk("rst_core_rst", core_rst_o, 1);
        chk("rst_valid", trace_valid_o, 0);
        chk("rst_ovf", trace_overflow_o, 0);
        chk("rst_halted", halted_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_count", cycle_count_o, 0);
        rst_i = 1'b1;
        tick();
        chk("idle_state", state_o, 0);

        // Run A: reset sequencing, x0 filtering, then timeout with an empty FIFO.
        enter_run();
        trace_ready_i = 1'b1;
        wb(5'd5, 32'h11);
        chk("no_bypass_valid", trace_valid_o, 1);
        wb(5'd0, 32'h22);
        wb(5'd6, 32'h33);
        repeat (20 - rc) tick();
        running = 1'b0;
        chk("tmo_state", state_o, 3);
        chk("tmo_flag", timeout_o, 1);
        chk("tmo_halted", halted_o, 0);
        chk("tmo_count", cycle_count_o, 20);
        chk("tmo_core_rst", core_rst_o, 1);
        tick();
        chk("tmo_done_state", state_o, 4);
        chk("tmo_done", done_o, 1);
        chk("tmo_count_hold", cycle_count_o, 20);
        tick();
        chk("done_hold", state_o, 4);

        // Run B: overflow with ready low, entries kept in order.
        enter_run();
        trace_ready_i = 1'b0;
        for (int i = 1; i <= 6; i++) wb(5'(i), 32'hA0 + 32'(i));
        chk("ovf_valid", trace_valid_o, 1);
        chk("ovf_head_stable", trace_addr_o, 1);
        trace_ready_i = 1'b1;
        repeat (6) tick();
        chk("ovf_drained", trace_valid_o, 0);
        instruction_if_id_i = HALT;
        tick();
        instruction_if_id_i = NOP;
        running = 1'b0;
        chk("b_halted", halted_o, 1);
        chk("b_state", state_o, 3);
        chk("b_count", cycle_count_o, 32'(rc));
        tick();
        chk("b_done", done_o, 1);

        // Run C: halt at RUN cycle 10 with two entries pending.
        enter_run();
        trace_ready_i = 1'b0;
        repeat (7) tick();
        wb(5'd3, 32'hC3);
        wb(5'd4, 32'hC4);
        instruction_if_id_i = HALT;
        tick();
        instruction_if_id_i = NOP;
        running = 1'b0;
        chk("c_state_drain", state_o, 3);
        chk("c_halted", halted_o, 1);
        chk("c_timeout", timeout_o, 0);
        chk("c_count", cycle_count_o, 10);
        chk("c_valid", trace_valid_o, 1);
        addr_wb_i = 5'd7;
        data_wb_i = 32'h77;
        tick();
        chk("c_drain_hold", state_o, 3);
        trace_ready_i = 1'b1;
        tick();
        chk("c_drain_1", state_o, 3);
        tick();
        addr_wb_i = 5'd0;
        chk("c_drain_2", state_o, 3);
        tick();
        chk("c_done_state", state_o, 4);
        chk("c_done", done_o, 1);
        chk("c_count_hold", cycle_count_o, 10);
        chk("c_empty", trace_valid_o, 0);

        // Run D: halt and timeout on the same cycle.
        enter_run();
        repeat (19) tick();
        instruction_if_id_i = HALT;
        tick();
        instruction_if_id_i = NOP;
        running = 1'b0;
        chk("d_halted", halted_o, 1);
        chk("d_timeout", timeout_o, 0);
        chk("d_count", cycle_count_o, 20);
        tick();
        chk("d_done", done_o, 1);

        // Run E: async reset mid-run with entries queued.
        enter_run();
        trace_ready_i = 1'b0;
        wb(5'd8, 32'hE8);
        wb(5'd9, 32'hE9);
        wb(5'd10, 32'hEA);
        chk("e_valid_before", trace_valid_o, 1);
        #2 rst_i = 1'b0;
        #1;
        sb.delete();
        running = 1'b0;
        chk("e_async_valid", trace_valid_o, 0);
        chk("e_async_state", state_o, 0);
        chk("e_async_core_rst", core_rst_o, 1);
        chk("e_async_count", cycle_count_o, 0);
        repeat (2) tick();
        rst_i = 1'b1;
        tick();
        chk("e_idle", state_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
